// File: rtl/pdc_pkg.sv
// Shared types, default widths and the pattern-length clamp for pattern_det_ctrl.
package pdc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_DONE
   } state_t;

   localparam int PDC_MAX_LEN = 8;
   localparam int PDC_LEN_W   = 4;
   localparam int PDC_CNT_W   = 8;
   localparam int PDC_TO_W    = 16;

   // Zero-length patterns run as 1 bit; over-long ones are cut to the engine maximum.
   function automatic int unsigned clamp_len(input int unsigned len, input int unsigned max_len);
      if (len == 0) begin
         return 1;
      end else if (len > max_len) begin
         return max_len;
      end else begin
         return len;
      end
   endfunction

endpackage

// File: rtl/pdc_sat_counter.sv
// Saturating up-counter with a look-ahead compare: next_eq flags value+inc == cmp.
module pdc_sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             inc,
   input  logic [WIDTH-1:0] cmp,
   output logic [WIDTH-1:0] value,
   output logic             next_eq
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         value <= '0;
      end else if (inc && (value != '1)) begin
         value <= value + WIDTH'(1);
      end
   end

   // One extra bit so a saturated count plus a pending increment never aliases a small target.
   assign next_eq = (({1'b0, value} + (WIDTH + 1)'(inc)) == {1'b0, cmp});

endmodule

// File: rtl/pattern_det_ctrl.sv
// Job controller for the serial pattern-detector engine: config handshake, clear, gated run, status.
// Optional first-hit position reporting is enabled with `define PDC_HIT_POS_EN.
module pattern_det_ctrl
   import pdc_pkg::*;
#(
   parameter int MAX_LEN = PDC_MAX_LEN,
   parameter int LEN_W   = PDC_LEN_W,
   parameter int CNT_W   = PDC_CNT_W,
   parameter int TO_W    = PDC_TO_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic [CNT_W-1:0]   cfg_target,
   input  logic [TO_W-1:0]    cfg_timeout,
   input  logic               start,
   input  logic               abort,
   input  logic               s_valid,
   input  logic               s_data,
   output logic               det_clear,
   output logic [MAX_LEN-1:0] det_pattern,
   output logic [LEN_W-1:0]   det_len,
   output logic               det_overlap,
   output logic               det_valid,
   output logic               det_data,
   input  logic               det_hit,
   output logic               busy,
   output logic               done,
   output logic               timed_out,
   output logic [CNT_W-1:0]   match_cnt
`ifdef PDC_HIT_POS_EN
   ,
   output logic [TO_W-1:0]    first_hit_pos
`endif
);

   state_t            state;
   logic [CNT_W-1:0]  target;
   logic [TO_W-1:0]   timeout;
   logic              cfg_loaded;
   logic [TO_W-1:0]   bit_cnt;
   logic              match_eq;
   logic              bit_eq;
   logic              in_run;
   logic              cap;
   logic              hit_target;
   logic              hit_timeout;

   assign in_run      = (state == ST_RUN);
   assign cap         = cfg_valid && (state == ST_IDLE);
   assign det_valid   = in_run && s_valid;
   assign det_data    = s_data;
   assign hit_target  = (target != '0) && match_eq;
   assign hit_timeout = (timeout != '0) && bit_eq;

   pdc_sat_counter #(.WIDTH(CNT_W)) u_match_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ST_CLEAR),
      .inc     (in_run && det_hit),
      .cmp     (target),
      .value   (match_cnt),
      .next_eq (match_eq)
   );

   pdc_sat_counter #(.WIDTH(TO_W)) u_bit_cnt (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ST_CLEAR),
      .inc     (in_run && s_valid),
      .cmp     (timeout),
      .value   (bit_cnt),
      .next_eq (bit_eq)
   );

`ifdef PDC_HIT_POS_EN
   // The hit pulse arrives with its own bit, so its position is the post-increment count.
   logic [TO_W-1:0] bit_next;

   always_comb begin
      bit_next = bit_cnt;
      if (s_valid && (bit_cnt != '1)) begin
         bit_next = bit_cnt + TO_W'(1);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         cfg_ready   <= 1'b1;
         det_clear   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         timed_out   <= 1'b0;
         det_pattern <= '0;
         det_len     <= LEN_W'(1);
         det_overlap <= 1'b0;
         target      <= '0;
         timeout     <= '0;
         cfg_loaded  <= 1'b0;
`ifdef PDC_HIT_POS_EN
         first_hit_pos <= '0;
`endif
      end else begin
         det_clear <= 1'b0;
         done      <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (cap) begin
                  det_pattern <= cfg_pattern;
                  det_len     <= LEN_W'(clamp_len(32'(cfg_len), MAX_LEN));
                  det_overlap <= cfg_overlap;
                  target      <= cfg_target;
                  timeout     <= cfg_timeout;
                  cfg_loaded  <= 1'b1;
               end
               if (start && (cfg_loaded || cap)) begin
                  state     <= ST_CLEAR;
                  cfg_ready <= 1'b0;
                  det_clear <= 1'b1;
                  busy      <= 1'b1;
                  timed_out <= 1'b0;
               end
            end
            ST_CLEAR: begin
               state <= ST_RUN;
`ifdef PDC_HIT_POS_EN
               first_hit_pos <= '0;
`endif
            end
            ST_RUN: begin
`ifdef PDC_HIT_POS_EN
               if (det_hit && (match_cnt == '0)) begin
                  first_hit_pos <= bit_next;
               end
`endif
               // abort > target > timeout
               if (abort || hit_target || hit_timeout) begin
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  timed_out <= !abort && !hit_target;
`ifdef PDC_HIT_POS_EN
                  if (!det_hit && (match_cnt == '0)) begin
                     first_hit_pos <= '1;
                  end
`endif
               end
            end
            ST_DONE: begin
               state     <= ST_IDLE;
               cfg_ready <= 1'b1;
            end
            default: begin
               state     <= ST_IDLE;
               cfg_ready <= 1'b1;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pattern_det_ctrl.sv
// Directed bench for pattern_det_ctrl with a behavioural detector engine driving det_hit.
module tb_pattern_det_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [7:0]  cfg_pattern;
   logic [3:0]  cfg_len;
   logic        cfg_overlap;
   logic [7:0]  cfg_target;
   logic [15:0] cfg_timeout;
   logic        start;
   logic        abort;
   logic        s_valid;
   logic        s_data;
   logic        det_clear;
   logic [7:0]  det_pattern;
   logic [3:0]  det_len;
   logic        det_overlap;
   logic        det_valid;
   logic        det_data;
   logic        det_hit;
   logic        busy;
   logic        done;
   logic        timed_out;
   logic [7:0]  match_cnt;
`ifdef PDC_HIT_POS_EN
   logic [15:0] first_hit_pos;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   pattern_det_ctrl #(.MAX_LEN(8), .LEN_W(4), .CNT_W(8), .TO_W(16)) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_pattern (cfg_pattern),
      .cfg_len     (cfg_len),
      .cfg_overlap (cfg_overlap),
      .cfg_target  (cfg_target),
      .cfg_timeout (cfg_timeout),
      .start       (start),
      .abort       (abort),
      .s_valid     (s_valid),
      .s_data      (s_data),
      .det_clear   (det_clear),
      .det_pattern (det_pattern),
      .det_len     (det_len),
      .det_overlap (det_overlap),
      .det_valid   (det_valid),
      .det_data    (det_data),
      .det_hit     (det_hit),
      .busy        (busy),
      .done        (done),
      .timed_out   (timed_out),
      .match_cnt   (match_cnt)
`ifdef PDC_HIT_POS_EN
      ,
      .first_hit_pos (first_hit_pos)
`endif
   );

   // Behavioural detector: shift register, hit in the same cycle as the completing bit.
   logic [7:0]  sh;
   int unsigned fill;
   logic [7:0]  win;
   logic [7:0]  mask;
   logic [7:0]  pref;
   int          shamt;

   always_comb begin
      shamt   = 8 - int'(det_len);
      win     = {sh[6:0], det_data};
      mask    = 8'hFF >> shamt;
      pref    = det_pattern >> shamt;
      det_hit = det_valid && ((fill + 1) >= 32'(det_len)) && ((win & mask) == (pref & mask));
   end

   always @(posedge clk) begin
      if (det_clear) begin
         sh   <= '0;
         fill <= 0;
      end else if (det_valid) begin
         sh <= win;
         if (det_hit && !det_overlap) fill <= 0;
         else if (fill < 8) fill <= fill + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic [3:0] len_in;
      logic [7:0] pat;
      logic [3:0] exp_len;
   } clamp_vec_t;

   typedef struct {
      logic [7:0]  pat;
      logic [3:0]  len;
      logic        ovl;
      logic [7:0]  target;
      logic [15:0] timeout;
      logic [31:0] bits;
      int          nbits;
      int          exp_end;   // 1-based bit that ends the job; 0 = job is aborted after the stream
      logic [7:0]  exp_cnt;
      logic        exp_to;
      logic [15:0] exp_pos;
   } job_t;

   clamp_vec_t cvec[6];
   job_t       jobs[7];

   task automatic run_job(input job_t j, input int idx);
      int end_bit;
      end_bit     = 0;
      cfg_valid   = 1'b1;
      cfg_pattern = j.pat;
      cfg_len     = j.len;
      cfg_overlap = j.ovl;
      cfg_target  = j.target;
      cfg_timeout = j.timeout;
      start       = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      start     = 1'b0;
      check($sformatf("job%0d_det_clear", idx), det_clear, 1'b1);
      check($sformatf("job%0d_det_pattern", idx), det_pattern, j.pat);
      check($sformatf("job%0d_busy", idx), busy, 1'b1);
      @(negedge clk);
      check($sformatf("job%0d_clear_1cyc", idx), det_clear, 1'b0);
      for (int i = 1; i <= j.nbits; i++) begin
         s_valid = 1'b1;
         s_data  = j.bits[j.nbits - i];
         if (i == 1) begin
            #1;
            check($sformatf("job%0d_det_valid", idx), det_valid, 1'b1);
         end
         @(negedge clk);
         if (done) begin
            end_bit = i;
            break;
         end
      end
      s_valid = 1'b0;
      s_data  = 1'b0;
      if (end_bit == 0 && j.exp_end == 0) begin
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         check($sformatf("job%0d_abort_done", idx), done, 1'b1);
      end
      check($sformatf("job%0d_end_bit", idx), 32'(end_bit), 32'(j.exp_end));
      check($sformatf("job%0d_match_cnt", idx), match_cnt, j.exp_cnt);
      check($sformatf("job%0d_timed_out", idx), timed_out, j.exp_to);
      check($sformatf("job%0d_busy_done", idx), busy, 1'b0);
`ifdef PDC_HIT_POS_EN
      check($sformatf("job%0d_first_hit_pos", idx), first_hit_pos, j.exp_pos);
`endif
      @(negedge clk);
      check($sformatf("job%0d_done_1cyc", idx), done, 1'b0);
      check($sformatf("job%0d_cfg_ready", idx), cfg_ready, 1'b1);
      if (busy) begin
         abort = 1'b1;
         @(negedge clk);
         abort = 1'b0;
         repeat (2) @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      cvec[0] = '{4'd0,  8'hA5, 4'd1};
      cvec[1] = '{4'd12, 8'h3C, 4'd8};
      cvec[2] = '{4'd8,  8'h81, 4'd8};
      cvec[3] = '{4'd1,  8'h80, 4'd1};
      cvec[4] = '{4'd5,  8'hC8, 4'd5};
      cvec[5] = '{4'd15, 8'h7E, 4'd8};

      jobs[0] = '{8'b11001000, 4'd5, 1'b0, 8'd2, 16'd0,  32'b1100111001,     10, 10, 8'd2, 1'b0, 16'd5};
      jobs[1] = '{8'b11001000, 4'd5, 1'b0, 8'd0, 16'd10, 32'b00000000000000, 14, 10, 8'd0, 1'b1, 16'hFFFF};
      jobs[2] = '{8'b10100000, 4'd3, 1'b0, 8'd1, 16'd6,  32'b00010100,        8,  6, 8'd1, 1'b0, 16'd6};
      jobs[3] = '{8'b11000000, 4'd2, 1'b1, 8'd0, 16'd5,  32'b11111,           5,  5, 8'd4, 1'b1, 16'd2};
      jobs[4] = '{8'b11000000, 4'd2, 1'b0, 8'd0, 16'd5,  32'b11111,           5,  5, 8'd2, 1'b1, 16'd2};
      jobs[5] = '{8'b10100000, 4'd3, 1'b0, 8'd0, 16'd0,  32'b1010,            4,  0, 8'd1, 1'b0, 16'd3};
      jobs[6] = '{8'b10100000, 4'd3, 1'b0, 8'd1, 16'd0,  32'b0000101,         7,  7, 8'd1, 1'b0, 16'd7};

      rst = 1'b1; cfg_valid = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      cfg_target = '0; cfg_timeout = '0; start = 1'b0; abort = 1'b0; s_valid = 1'b0; s_data = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check("rst_cfg_ready", cfg_ready, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_timed_out", timed_out, 1'b0);
      check("rst_match_cnt", match_cnt, 8'd0);
      check("rst_det_len", det_len, 4'd1);
      check("rst_det_pattern", det_pattern, 8'd0);
      check("rst_det_overlap", det_overlap, 1'b0);
      check("rst_det_clear", det_clear, 1'b0);
      s_valid = 1'b1;
      #1;
      check("idle_det_valid_gated", det_valid, 1'b0);
      s_valid = 1'b0;

      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("noconf_start_busy", busy, 1'b0);
      check("noconf_start_clear", det_clear, 1'b0);
      check("noconf_start_ready", cfg_ready, 1'b1);

      foreach (cvec[k]) begin
         cfg_valid   = 1'b1;
         cfg_len     = cvec[k].len_in;
         cfg_pattern = cvec[k].pat;
         @(negedge clk);
         cfg_valid = 1'b0;
         check($sformatf("clamp%0d_det_len", k), det_len, cvec[k].exp_len);
         check($sformatf("clamp%0d_det_pattern", k), det_pattern, cvec[k].pat);
      end

      foreach (jobs[k]) run_job(jobs[k], k);

      // Config loaded on its own, started later; a config offer during RUN must be refused.
      cfg_valid = 1'b1; cfg_pattern = 8'b10100000; cfg_len = 4'd3; cfg_overlap = 1'b0;
      cfg_target = 8'd0; cfg_timeout = 16'd0;
      @(negedge clk);
      cfg_valid = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("late_start_clear", det_clear, 1'b1);
      @(negedge clk);
      check("run_cfg_ready", cfg_ready, 1'b0);
      cfg_valid = 1'b1; cfg_pattern = 8'hFF; cfg_len = 4'd2; cfg_overlap = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
      check("run_cfg_pattern_kept", det_pattern, 8'b10100000);
      check("run_cfg_len_kept", det_len, 4'd3);
      check("run_cfg_overlap_kept", det_overlap, 1'b0);
      check("run_busy", busy, 1'b1);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_done", done, 1'b1);
      check("abort_timed_out", timed_out, 1'b0);
      @(negedge clk);
      check("abort_done_1cyc", done, 1'b0);
      check("abort_pattern_kept", det_pattern, 8'b10100000);

      // Reset in the middle of a job: immediate IDLE, no done pulse, config forgotten.
      cfg_valid = 1'b1; cfg_pattern = 8'b11000000; cfg_len = 4'd2; cfg_overlap = 1'b1;
      cfg_target = 8'd0; cfg_timeout = 16'd0; start = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0; start = 1'b0;
      @(negedge clk);
      s_valid = 1'b1; s_data = 1'b1;
      repeat (3) @(negedge clk);
      check("pre_rst_match_cnt", match_cnt, 8'd2);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; s_valid = 1'b0; s_data = 1'b0;
      check("midrst_busy", busy, 1'b0);
      check("midrst_done", done, 1'b0);
      check("midrst_cfg_ready", cfg_ready, 1'b1);
      check("midrst_match_cnt", match_cnt, 8'd0);
      check("midrst_det_len", det_len, 4'd1);
      begin
         logic seen;
         seen = 1'b0;
         repeat (3) begin
            @(negedge clk);
            if (done) seen = 1'b1;
         end
         check("midrst_no_done", seen, 1'b0);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("midrst_cfg_forgotten", busy, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pattern_det_ctrl.md
Name: pattern_det_ctrl

Overview:
Controller that configures and sequences the team's serial pattern-detector engine. It accepts a detection job over a valid/ready config handshake: pattern, length, overlap mode, target match count and bit timeout. On start it clears the detector, gates the serial stream into it and counts hits. It finishes on target reached, timeout or abort, then reports status.

Parameters:
MAX_LEN, 8, maximum pattern length in bits
LEN_W, 4, width of length field (must hold MAX_LEN)
CNT_W, 8, width of match counter and target
TO_W, 16, width of bit counter and timeout

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cfg_valid  in  1  config offer
cfg_ready  out  1  config accept (high only in IDLE)
cfg_pattern  in  MAX_LEN  pattern, MSB-first, left-aligned in [MAX_LEN-1 -: len]
cfg_len  in  LEN_W  pattern length
cfg_overlap  in  1  1 = overlapping detection
cfg_target  in  CNT_W  matches to finish; 0 = run until timeout/abort
cfg_timeout  in  TO_W  max stream bits; 0 = no timeout
start  in  1  launch job (pulse)
abort  in  1  terminate running job
s_valid  in  1  stream bit valid
s_data  in  1  stream bit
det_clear  out  1  one-cycle detector clear
det_pattern  out  MAX_LEN  active pattern
det_len  out  LEN_W  active length (clamped)
det_overlap  out  1  active overlap mode
det_valid  out  1  gated stream valid
det_data  out  1  stream data passthrough
det_hit  in  1  detector match pulse
busy  out  1  high in CLEAR/RUN
done  out  1  one-cycle completion pulse
timed_out  out  1  job ended by timeout
match_cnt  out  CNT_W  hits in current/last job

Behaviour:
- Reset: state IDLE; cfg_ready 1; det_clear, det_valid, busy, done, timed_out 0; match_cnt 0; det_pattern 0, det_len 1, det_overlap 0; cfg_loaded flag 0. Reset mid-job aborts immediately with no done pulse.
- States: IDLE, CLEAR, RUN, DONE.
- IDLE: cfg_valid&cfg_ready captures config into active regs and sets cfg_loaded. cfg_len 0 clamps to 1; cfg_len > MAX_LEN clamps to MAX_LEN. If start=1 and (cfg_loaded or same-cycle cfg capture): go to CLEAR; the same-cycle config is the one used. Start without any loaded config is ignored. Start clears timed_out.
- CLEAR: det_clear=1 for exactly one cycle; match_cnt and bit_cnt go to 0; then RUN. det_pattern/len/overlap are stable from CLEAR through DONE.
- RUN: det_valid = s_valid, det_data = s_data (combinational, zero latency). det_valid is 0 in all other states.
  - Each s_valid increments bit_cnt, saturating.
  - Each det_hit increments match_cnt, saturating at all-ones. det_hit outside RUN is ignored.
  - Exit priority, same cycle: abort > target > timeout.
  - Target: target != 0 and match_cnt + det_hit == target -> DONE.
  - Timeout: timeout != 0 and bit_cnt + s_valid == timeout, target not met -> DONE, timed_out<=1.
  - Abort -> DONE, timed_out 0.
- DONE: done=1 for one cycle, then IDLE. match_cnt holds until next CLEAR; timed_out holds until next start.
- cfg_valid is ignored outside IDLE; cfg_ready is 0 there.
- Latency: start at cycle t -> det_clear at t+1 -> first gated bit at t+2. Final hit at t -> done at t+1.

Optional Feature:
PDC_HIT_POS_EN
- Defined: adds output first_hit_pos [TO_W], loaded with bit_cnt (position of the hit bit, 1-based) on the first det_hit of a job. Cleared in CLEAR; holds otherwise; all-ones if the job ends with no hit.
- Undefined: port and logic are absent.

Decomposition:
- Package pdc_pkg: state enum (IDLE/CLEAR/RUN/DONE), default widths, clamp function for length.
- Sub-module pdc_sat_counter (param width; clear, inc, value, would-equal-compare output), instantiated for match_cnt and bit_cnt.

Test Plan:
- Config pattern 5'b11001, len 5, overlap 0, target 2, timeout 0; start; stream 1100111001 -> two det_hit pulses, match_cnt 2, done one cycle after 2nd hit, timed_out 0.
- Target 0, timeout 10; stream with no matches -> done one cycle after 10th valid bit, timed_out 1, match_cnt 0.
- Target 1, timeout 6; hit arrives on the 6th bit -> done, timed_out 0 (target beats timeout).
- cfg_len 0 -> det_len 1; cfg_len 12 with MAX_LEN 8 -> det_len 8; cfg_valid during RUN -> cfg_ready 0, active config unchanged.
- Start without prior config -> stays IDLE. Config+start same cycle -> det_clear next cycle with new pattern. Abort mid-RUN -> done, timed_out 0. rst mid-RUN -> IDLE, no done.
- With PDC_HIT_POS_EN: first hit on the 7th valid bit -> first_hit_pos 7; no-hit job -> all-ones.
